sprite_move_sequencer: RTL and testbench
========================================

// Module: sprite_move_sequencer
// PURPOSE
//  Frame-level scheduler for the shared VGA pixel-plot port: draw sprite, wait one frame period, erase it, apply key moves, redraw.
//  Sole master of plot/x/y/colour into the VGA adapter; the adapter paces writes through plot_ready.
//  Key inputs are raw push buttons, synchronised and edge-detected here.
// PARAMETERS
//  SPR_W        5        sprite width in pixels (>=1)
//  SPR_H        5        sprite height in pixels (>=1)
//  X_INIT       0        sprite left column after reset
//  X_MAX        155      max left column; X_MAX+SPR_W-1 <= 159
//  Y_POS        100      sprite top row (fixed); Y_POS+SPR_H-1 <= 119
//  WAIT_CYCLES  833333   clk cycles spent in WAIT (>=1)
//  FG_COLOUR    3'b111   draw colour
//  BG_COLOUR    3'b000   erase colour
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  asynchronous, active-high reset
//  key_left_n   in   1  raw active-low button, move left; asynchronous to clk
//  key_right_n  in   1  raw active-low button, move right; asynchronous to clk
//  plot_ready   in   1  adapter accepts pixel this cycle when plot&&plot_ready
//  plot         out  1  pixel write request
//  x_out        out  8  pixel column
//  y_out        out  7  pixel row
//  colour       out  3  pixel colour
//  op           out  2  phase: 00 DRAW, 01 ERASE, 10 WAIT, 11 UPDATE
//  pos_x        out  8  current sprite left column
//  frame_done   out  1  one-cycle pulse in UPDATE
// BEHAVIOUR
//  Reset (async): state=DRAW, col=row=0, wait_cnt=0, pos_x=X_INIT, pending moves cleared, sync FFs=1.
//   While reset high: plot=0, frame_done=0, op=00, x_out=X_INIT, y_out=Y_POS, colour=FG_COLOUR.
//  Keys: 2-FF synchroniser each, then falling-edge detect -> 1-cycle pulse; held key = one pulse only.
//   Pulse sets left_pend/right_pend; flags held until UPDATE.
//  Outputs are combinational decodes of registered state/counters: x_out=pos_x+col, y_out=Y_POS+row.
//  DRAW: plot=1, colour=FG_COLOUR. Pixel accepted when plot_ready=1; then col++;
//   col==SPR_W-1 wraps to 0 and row++. plot_ready=0 holds x/y/colour stable.
//   Acceptance of pixel (SPR_W-1,SPR_H-1) -> WAIT, col=row=0. Exactly SPR_W*SPR_H accepts per pass.
//  WAIT: plot=0; wait_cnt counts 0..WAIT_CYCLES-1; on WAIT_CYCLES-1 -> ERASE, wait_cnt=0.
//  ERASE: identical scan to DRAW at same pos_x, colour=BG_COLOUR; last accept -> UPDATE.
//  UPDATE (1 cycle): plot=0, frame_done=1, -> DRAW.
//   left_pend only: pos_x = (pos_x==0) ? 0 : pos_x-1 (saturate, no wrap).
//   right_pend only: pos_x = (pos_x==X_MAX) ? X_MAX : pos_x+1 (saturate).
//   both pending: no move. Both flags cleared.
//   Key pulse in the UPDATE cycle itself: set wins; flag stays pending for next frame.
//  pos_x changes only in UPDATE, so ERASE always covers the last drawn footprint.
//  Reset mid-scan: pass abandoned; after release DRAW restarts at pixel (0,0) at X_INIT.
//   Stale pixels on screen are not erased.
//  No illegal states reachable; default branch -> DRAW.
// TESTING (bench: WAIT_CYCLES=10, other defaults)
//  1 Reset, plot_ready=1 tied -> 25 plots at x0..4/y100..104 col 7, op=10 for 10 cycles, 25 plots col 0, frame_done pulse, redraw at x0.
//  2 plot_ready alternating 1/0 during DRAW -> still 25 accepts, x/y held on ready=0 cycles, no pixel skipped or repeated.
//  3 key_right_n low 3 cycles during WAIT at pos 0 -> after UPDATE pos_x=1, next DRAW covers x1..5; key held 3 frames -> one move only.
//  4 Left press at pos_x=0 -> pos_x stays 0; X_INIT=155 with right press -> stays 155.
//  5 Left and right both pressed in one frame -> pos_x unchanged; press landing exactly in UPDATE cycle -> applied next frame.
//  6 Assert reset during DRAW after 12 accepts -> plot=0 immediately; release -> scan restarts at (X_INIT,Y_POS), op=00.

Source files
------------

// File: rtl/sprite_move_sequencer_if.sv
// Pixel-plot bus between the sprite sequencer and the VGA adapter.
//   plot        pixel write request (sequencer -> adapter)
//   plot_ready  adapter accepts the pixel this cycle when plot && plot_ready
//   x_out       pixel column, 0..159
//   y_out       pixel row, 0..119
//   colour      3-bit pixel colour
// A write completes on the rising clock edge where plot and plot_ready are
// both high. While plot_ready is low, the master holds x/y/colour stable.
interface sprite_move_sequencer_if;
  logic       plot;
  logic       plot_ready;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;

  modport master (
    output plot,
    output x_out,
    output y_out,
    output colour,
    input  plot_ready
  );

  modport slave (
    input  plot,
    input  x_out,
    input  y_out,
    input  colour,
    output plot_ready
  );
endinterface

// File: rtl/sprite_move_sequencer.sv
// Frame-level scheduler for the shared VGA pixel-plot port.
// Each frame runs through four phases:
//   1. Draw the sprite.
//   2. Wait one frame period.
//   3. Erase the sprite.
//   4. Apply the pending key moves. The next frame then redraws the sprite.
// This block is the only master of the plot bus. The adapter paces the
// writes through plot_ready.
// Ports:
//   clk          system clock; all logic runs on the rising edge
//   reset        asynchronous, active-high reset
//   key_left_n   raw active-low push button, move left; asynchronous to clk
//   key_right_n  raw active-low push button, move right; asynchronous to clk
//   pix          plot bus (master side): plot, plot_ready, x_out, y_out, colour
//   op           current phase: 00 DRAW, 01 ERASE, 10 WAIT, 11 UPDATE
//   pos_x        current sprite left column
//   frame_done   one-cycle pulse during UPDATE
module sprite_move_sequencer #(
  parameter int         SPR_W       = 5,
  parameter int         SPR_H       = 5,
  parameter int         X_INIT      = 0,
  parameter int         X_MAX       = 155,
  parameter int         Y_POS       = 100,
  parameter int         WAIT_CYCLES = 833333,
  parameter logic [2:0] FG_COLOUR   = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_left_n,
  input  logic                          key_right_n,
  sprite_move_sequencer_if.master       pix,
  output logic [1:0]                    op,
  output logic [7:0]                    pos_x,
  output logic                          frame_done
);

  localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [7:0]      COL_LAST = 8'(SPR_W - 1);
  localparam logic [6:0]      ROW_LAST = 7'(SPR_H - 1);
  localparam logic [7:0]      X_START  = 8'(X_INIT);
  localparam logic [7:0]      X_LIMIT  = 8'(X_MAX);
  localparam logic [6:0]      Y_BASE   = 7'(Y_POS);
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(WAIT_CYCLES - 1);

  // Encodings are chosen so that op is simply the state register.
  typedef enum logic [1:0] {
    S_DRAW   = 2'b00,
    S_ERASE  = 2'b01,
    S_WAIT   = 2'b10,
    S_UPDATE = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_col;
  logic [6:0]      r_row;
  logic [WC_W-1:0] r_wait_cnt;
  logic [7:0]      r_pos_x;
  logic            r_left_pend;
  logic            r_right_pend;

  // Three flops per key: two synchronise, the third holds the previous
  // synchronised value for falling-edge detection.
  logic r_kl_s1, r_kl_s2, r_kl_s3;
  logic r_kr_s1, r_kr_s2, r_kr_s3;

  logic       w_kl_pulse;
  logic       w_kr_pulse;
  logic       w_scan;
  logic       w_accept;
  logic       w_last_col;
  logic       w_last_px;
  logic       w_frame_done;
  logic [2:0] w_colour;

  // Left move that stops at column 0 instead of wrapping.
  function automatic logic [7:0] sat_dec(input logic [7:0] p);
    return (p == 8'd0) ? 8'd0 : p - 8'd1;
  endfunction

  // Right move that stops at the rightmost legal left column.
  function automatic logic [7:0] sat_inc(input logic [7:0] p);
    return (p == X_LIMIT) ? X_LIMIT : p + 8'd1;
  endfunction

  // Key synchronisers. They idle high because the buttons are active-low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kl_s1 <= 1'b1;
      r_kl_s2 <= 1'b1;
      r_kl_s3 <= 1'b1;
      r_kr_s1 <= 1'b1;
      r_kr_s2 <= 1'b1;
      r_kr_s3 <= 1'b1;
    end else begin
      r_kl_s1 <= key_left_n;
      r_kl_s2 <= r_kl_s1;
      r_kl_s3 <= r_kl_s2;
      r_kr_s1 <= key_right_n;
      r_kr_s2 <= r_kr_s1;
      r_kr_s3 <= r_kr_s2;
    end
  end

  // A press is a high-to-low transition. A held button therefore produces
  // only one pulse.
  assign w_kl_pulse = r_kl_s3 & ~r_kl_s2;
  assign w_kr_pulse = r_kr_s3 & ~r_kr_s2;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_DRAW;
    else       r_state <= w_state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_scan       = 1'b0;
    w_accept     = 1'b0;
    w_frame_done = 1'b0;
    w_colour     = FG_COLOUR;
    w_last_col   = (r_col == COL_LAST);
    w_last_px    = w_last_col && (r_row == ROW_LAST);
    case (r_state)
      S_DRAW: begin
        w_scan   = 1'b1;
        w_accept = pix.plot_ready;
        if (w_accept && w_last_px) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == WC_LAST) w_state_nxt = S_ERASE;
      end
      S_ERASE: begin
        w_scan   = 1'b1;
        w_colour = BG_COLOUR;
        w_accept = pix.plot_ready;
        if (w_accept && w_last_px) w_state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = S_DRAW;
      end
      default: w_state_nxt = S_DRAW;
    endcase
  end

  // Raster counters for the sprite footprint. They advance only on an
  // accepted pixel, so a stalled adapter sees a stable address. The last
  // pixel wraps both counters back to (0,0), ready for the next scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= 8'd0;
      r_row <= 7'd0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= 8'd0;
        r_row <= (r_row == ROW_LAST) ? 7'd0 : r_row + 7'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  // Frame-period timer. It is held at zero outside WAIT so that every WAIT
  // lasts exactly WAIT_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= (r_wait_cnt == WC_LAST) ? '0 : r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Pending moves. UPDATE consumes the flags, but a pulse arriving in that
  // same cycle re-arms its flag for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left_pend  <= 1'b0;
      r_right_pend <= 1'b0;
    end else if (r_state == S_UPDATE) begin
      r_left_pend  <= w_kl_pulse;
      r_right_pend <= w_kr_pulse;
    end else begin
      r_left_pend  <= r_left_pend  | w_kl_pulse;
      r_right_pend <= r_right_pend | w_kr_pulse;
    end
  end

  // Position changes only in UPDATE, which is after the erase pass. ERASE
  // therefore always covers the footprint that was drawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos_x <= X_START;
    end else if (r_state == S_UPDATE) begin
      case ({r_left_pend, r_right_pend})
        2'b10:   r_pos_x <= sat_dec(r_pos_x);
        2'b01:   r_pos_x <= sat_inc(r_pos_x);
        default: r_pos_x <= r_pos_x;
      endcase
    end
  end

  // Reset lands in DRAW, so plot is gated by reset to keep the bus quiet
  // while reset is asserted.
  assign pix.plot   = w_scan & ~reset;
  assign pix.x_out  = r_pos_x + r_col;
  assign pix.y_out  = Y_BASE + r_row;
  assign pix.colour = w_colour;
  assign op         = r_state;
  assign pos_x      = r_pos_x;
  assign frame_done = w_frame_done & ~reset;

endmodule

// File: tb/tb_sprite_move_sequencer.sv
module tb_sprite_move_sequencer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  pix_t exp_q[$];

  // DUT 0: default origin, scoreboarded.
  logic       rst0 = 1'b1;
  logic       kl0 = 1'b1;
  logic       kr0 = 1'b1;
  logic [1:0] op0;
  logic [7:0] pos_x0;
  logic       frame_done0;
  sprite_move_sequencer_if ifc0 ();

  sprite_move_sequencer #(.WAIT_CYCLES(10)) dut0 (
    .clk        (clk),
    .reset      (rst0),
    .key_left_n (kl0),
    .key_right_n(kr0),
    .pix        (ifc0),
    .op         (op0),
    .pos_x      (pos_x0),
    .frame_done (frame_done0)
  );

  // DUT 1: starts at the right edge, free-running with plot_ready tied high.
  logic       rst1 = 1'b1;
  logic       kl1 = 1'b1;
  logic       kr1 = 1'b1;
  logic [1:0] op1;
  logic [7:0] pos_x1;
  logic       frame_done1;
  sprite_move_sequencer_if ifc1 ();

  sprite_move_sequencer #(.WAIT_CYCLES(10), .X_INIT(155)) dut1 (
    .clk        (clk),
    .reset      (rst1),
    .key_left_n (kl1),
    .key_right_n(kr1),
    .pix        (ifc1),
    .op         (op1),
    .pos_x      (pos_x1),
    .frame_done (frame_done1)
  );

  assign ifc1.plot_ready = 1'b1;

  // Scoreboard monitor for DUT 0. An accepted pixel pops the queue. A stalled
  // pixel must match the head of the queue without consuming it.
  always @(negedge clk) begin
    pix_t e;
    if (!rst0 && ifc0.plot) begin
      if (ifc0.plot_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_extra got x=%0d y=%0d c=%0d with nothing expected",
                   ifc0.x_out, ifc0.y_out, ifc0.colour);
        end else begin
          e = exp_q.pop_front();
          if ({ifc0.x_out, ifc0.y_out, ifc0.colour} !== e) begin
            errors++;
            $display("FAIL pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     ifc0.x_out, ifc0.y_out, ifc0.colour, e.x, e.y, e.c);
          end
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        e = exp_q[0];
        if ({ifc0.x_out, ifc0.y_out, ifc0.colour} !== e) begin
          errors++;
          $display("FAIL pixel_hold got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                   ifc0.x_out, ifc0.y_out, ifc0.colour, e.x, e.y, e.c);
        end
      end
    end
  end

  // Runs one full frame on DUT 0: draw, wait, erase, update.
  // Pushes the expected pixels, drives plot_ready, and reports how many
  // cycles it saw in WAIT and whether frame_done appeared.
  task automatic do_frame(input logic [7:0] x, input bit alt, output int wcnt,
                          output bit done);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_q.push_back({8'(x + c), 7'(100 + r), 3'b111});
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_q.push_back({8'(x + c), 7'(100 + r), 3'b000});
    wcnt = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      ifc0.plot_ready = alt ? ~ifc0.plot_ready : 1'b1;
      @(negedge clk);
      if (op0 == 2'b10) wcnt++;
      if (frame_done0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    ifc0.plot_ready = 1'b0;
  endtask

  // Presses the selected keys on DUT 0 for 3 cycles, once it reaches WAIT.
  task automatic press_in_wait(input bit l, input bit r);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (op0 == 2'b10) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_wait got no WAIT within bound want op=10");
    end
    if (l) kl0 = 1'b0;
    if (r) kr0 = 1'b0;
    repeat (3) @(negedge clk);
    kl0 = 1'b1;
    kr0 = 1'b1;
  endtask

  // Presses right so that the synchronised pulse falls exactly in UPDATE.
  // The press is made while the erase scan shows pixel 23, i.e. (x+3, 104).
  task automatic press_at_update(input logic [7:0] x);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (op0 == 2'b01 && ifc0.x_out == 8'(x + 3) && ifc0.y_out == 7'd104) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_px23 got no erase pixel 23 within bound want seen=1");
    end
    kr0 = 1'b0;
    repeat (4) @(negedge clk);
    kr0 = 1'b1;
  endtask

  task automatic test_reset;
    ifc0.plot_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifc0.plot !== 1'b0) begin errors++; $display("FAIL rst_plot got %0b want 0", ifc0.plot); end
    checks++; if (frame_done0 !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %0b want 0", frame_done0); end
    checks++; if (op0 !== 2'b00) begin errors++; $display("FAIL rst_op got %0b want 00", op0); end
    checks++; if (ifc0.x_out !== 8'd0) begin errors++; $display("FAIL rst_x got %0d want 0", ifc0.x_out); end
    checks++; if (ifc0.y_out !== 7'd100) begin errors++; $display("FAIL rst_y got %0d want 100", ifc0.y_out); end
    checks++; if (ifc0.colour !== 3'b111) begin errors++; $display("FAIL rst_colour got %0d want 7", ifc0.colour); end
    checks++; if (pos_x0 !== 8'd0) begin errors++; $display("FAIL rst_pos got %0d want 0", pos_x0); end
    checks++; if (ifc1.x_out !== 8'd155) begin errors++; $display("FAIL rst_x_dut1 got %0d want 155", ifc1.x_out); end
    checks++; if (ifc1.plot !== 1'b0) begin errors++; $display("FAIL rst_plot_dut1 got %0b want 0", ifc1.plot); end
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
  endtask

  task automatic test_basic_frame;
    int w;
    bit d;
    do_frame(8'd0, 1'b0, w, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL basic_done got %0b want 1", d); end
    checks++; if (w != 10) begin errors++; $display("FAIL basic_wait got %0d want 10", w); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left got %0d want 0", exp_q.size()); end
    checks++; if (frame_done0 !== 1'b0) begin errors++; $display("FAIL basic_fd_pulse got %0b want 0", frame_done0); end
    checks++; if (op0 !== 2'b00) begin errors++; $display("FAIL basic_redraw_op got %0b want 00", op0); end
    checks++; if (ifc0.x_out !== 8'd0) begin errors++; $display("FAIL basic_redraw_x got %0d want 0", ifc0.x_out); end
  endtask

  task automatic test_ready_toggle;
    int w;
    bit d;
    do_frame(8'd0, 1'b1, w, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL toggle_done got %0b want 1", d); end
    checks++; if (w != 10) begin errors++; $display("FAIL toggle_wait got %0d want 10", w); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL toggle_left got %0d want 0", exp_q.size()); end
    checks++; if (pos_x0 !== 8'd0) begin errors++; $display("FAIL toggle_pos got %0d want 0", pos_x0); end
  endtask

  task automatic test_key_right;
    int w;
    bit d;
    fork
      do_frame(8'd0, 1'b0, w, d);
      press_in_wait(1'b0, 1'b1);
    join
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL right_done got %0b want 1", d); end
    checks++; if (pos_x0 !== 8'd1) begin errors++; $display("FAIL right_pos got %0d want 1", pos_x0); end
    // Key held across three frames: only the first frame moves.
    kr0 = 1'b0;
    for (int f = 0; f < 3; f++) begin
      do_frame((f == 0) ? 8'd1 : 8'd2, 1'b0, w, d);
      checks++; if (d !== 1'b1) begin errors++; $display("FAIL hold_done got %0b want 1", d); end
      checks++; if (pos_x0 !== 8'd2) begin errors++; $display("FAIL hold_pos f=%0d got %0d want 2", f, pos_x0); end
    end
    kr0 = 1'b1;
  endtask

  task automatic test_saturate;
    int w;
    bit d;
    bit seen;
    logic [7:0] start_x;
    logic [7:0] want;
    for (int f = 0; f < 3; f++) begin
      start_x = (f == 0) ? 8'd2 : (f == 1) ? 8'd1 : 8'd0;
      want    = (f == 0) ? 8'd1 : 8'd0;
      fork
        do_frame(start_x, 1'b0, w, d);
        press_in_wait(1'b1, 1'b0);
      join
      checks++; if (pos_x0 !== want) begin errors++; $display("FAIL left_pos f=%0d got %0d want %0d", f, pos_x0, want); end
    end
    // DUT 1 sits at X_MAX; a right press must not move it.
    kr1 = 1'b0;
    for (int f = 0; f < 2; f++) begin
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (frame_done1) seen = 1'b1;
      end
      @(posedge clk);
      #1;
      checks++; if (!seen) begin errors++; $display("FAIL dut1_frame got no frame_done want pulse"); end
      checks++; if (pos_x1 !== 8'd155) begin errors++; $display("FAIL right_sat got %0d want 155", pos_x1); end
      checks++; if (ifc1.x_out !== 8'd155) begin errors++; $display("FAIL right_sat_x got %0d want 155", ifc1.x_out); end
    end
    kr1 = 1'b1;
  endtask

  task automatic test_both_keys;
    int w;
    bit d;
    fork
      do_frame(8'd0, 1'b0, w, d);
      press_in_wait(1'b0, 1'b1);
    join
    checks++; if (pos_x0 !== 8'd1) begin errors++; $display("FAIL pre_both_pos got %0d want 1", pos_x0); end
    fork
      do_frame(8'd1, 1'b0, w, d);
      press_in_wait(1'b1, 1'b1);
    join
    checks++; if (pos_x0 !== 8'd1) begin errors++; $display("FAIL both_pos got %0d want 1", pos_x0); end
    fork
      do_frame(8'd1, 1'b0, w, d);
      press_at_update(8'd1);
    join
    checks++; if (pos_x0 !== 8'd1) begin errors++; $display("FAIL upd_press_now got %0d want 1", pos_x0); end
    do_frame(8'd1, 1'b0, w, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL upd_press_done got %0b want 1", d); end
    checks++; if (pos_x0 !== 8'd2) begin errors++; $display("FAIL upd_press_next got %0d want 2", pos_x0); end
  endtask

  task automatic test_reset_mid_scan;
    int w;
    bit d;
    int cnt = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_q.push_back({8'(2 + c), 7'(100 + r), 3'b111});
    for (int i = 0; i < 100 && cnt < 12; i++) begin
      @(posedge clk);
      #1;
      ifc0.plot_ready = 1'b1;
      @(negedge clk);
      if (ifc0.plot && ifc0.plot_ready) cnt++;
    end
    checks++; if (cnt != 12) begin errors++; $display("FAIL mid_accepts got %0d want 12", cnt); end
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    ifc0.plot_ready = 1'b0;
    #1;
    checks++; if (ifc0.plot !== 1'b0) begin errors++; $display("FAIL mid_rst_plot got %0b want 0", ifc0.plot); end
    checks++; if (pos_x0 !== 8'd0) begin errors++; $display("FAIL mid_rst_pos got %0d want 0", pos_x0); end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    #1;
    checks++; if (op0 !== 2'b00) begin errors++; $display("FAIL mid_rel_op got %0b want 00", op0); end
    checks++; if (ifc0.x_out !== 8'd0) begin errors++; $display("FAIL mid_rel_x got %0d want 0", ifc0.x_out); end
    checks++; if (ifc0.y_out !== 7'd100) begin errors++; $display("FAIL mid_rel_y got %0d want 100", ifc0.y_out); end
    checks++; if (ifc0.plot !== 1'b1) begin errors++; $display("FAIL mid_rel_plot got %0b want 1", ifc0.plot); end
    do_frame(8'd0, 1'b0, w, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL mid_frame_done got %0b want 1", d); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_left got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    ifc0.plot_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_ready_toggle();
    test_key_right();
    test_saturate();
    test_both_keys();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
